// File: rtl/drum_column_node.sv
`default_nettype none
// ============================================================================
// Module   : drum_column_node
// Purpose  : One column of the drum mesh. Keeps u(t) and u(t-1) for ROWS
//            nodes in two registered-read RAM banks. On each start it walks
//            the column row by row. For each row it presents
//            center/up/down/prev to the external combinational solver and
//            writes the solver result back.
// Ports    : clk, reset_n (async, active low)
//            start / busy / step_done        step handshake
//            init_we / init_addr / init_data write both banks while idle
//            u_center/u_up/u_down/u_prev     stencil values to the solver
//            u_next                          solver result for current row
//            row                             current row index
//            probe_out (DRUM_PROBE_EN only)  solver result at PROBE_ROW
// Options  : `define DRUM_PROBE_EN adds parameter PROBE_ROW and probe_out.
// Revision : 1.0 - initial release
// ============================================================================
module drum_column_node #(
  parameter int ROWS   = 30,
  parameter int ADDR_W = 10
`ifdef DRUM_PROBE_EN
  , parameter int PROBE_ROW = ROWS / 2
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              step_done,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [17:0]       init_data,
  output logic [17:0]       u_center,
  output logic [17:0]       u_up,
  output logic [17:0]       u_down,
  output logic [17:0]       u_prev,
  input  logic [17:0]       u_next,
  output logic [ADDR_W-1:0] row
`ifdef DRUM_PROBE_EN
  , output logic [17:0]     probe_out
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME0, S_PRIME1, S_PRIME2, S_CALC, S_WR, S_LOAD
  } state_t;

  // One extra bit so that row+2 cannot wrap when ROWS is near 2^ADDR_W.
  localparam logic [ADDR_W:0]   C_ROWS_X   = (ADDR_W+1)'(ROWS);
  localparam logic [ADDR_W-1:0] C_LAST_ROW = ADDR_W'(ROWS - 1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [17:0]       center_q, center_d, up_q, up_d, down_q, down_d;
  logic [17:0]       prev_q, prev_d, unext_q, unext_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W:0]   row_p1, row_p2;

  logic [17:0]       curr_mem [ROWS];
  logic [17:0]       prev_mem [ROWS];
  logic [17:0]       curr_rd_q, prev_rd_q;
  logic              curr_we, prev_we;
  logic [ADDR_W-1:0] curr_waddr, prev_waddr, curr_raddr, prev_raddr;
  logic [17:0]       curr_wdata, prev_wdata;

`ifdef DRUM_PROBE_EN
  localparam logic [ADDR_W-1:0] C_PROBE_ROW = ADDR_W'(PROBE_ROW);
  logic [17:0] probe_q, probe_d;
  assign probe_out = probe_q;
`endif

  assign row_p1 = {1'b0, row_q} + (ADDR_W+1)'(1);
  assign row_p2 = {1'b0, row_q} + (ADDR_W+1)'(2);

  // Memory banks: registered read, independent write, no reset (RAM blocks).
  always_ff @(posedge clk) begin
    if (curr_we) curr_mem[curr_waddr] <= curr_wdata;
    if (prev_we) prev_mem[prev_waddr] <= prev_wdata;
    curr_rd_q <= curr_mem[curr_raddr];
    prev_rd_q <= prev_mem[prev_raddr];
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    center_d   = center_q;
    up_d       = up_q;
    down_d     = down_q;
    prev_d     = prev_q;
    unext_d    = unext_q;
    row_d      = row_q;
    curr_we    = 1'b0;
    prev_we    = 1'b0;
    curr_waddr = row_q;
    prev_waddr = row_q;
    curr_wdata = unext_q;
    prev_wdata = center_q;
    curr_raddr = '0;
    prev_raddr = '0;
`ifdef DRUM_PROBE_EN
    probe_d    = probe_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Out-of-range init addresses are dropped rather than aliased.
        if (init_we && ({1'b0, init_addr} < C_ROWS_X)) begin
          curr_we    = 1'b1;
          prev_we    = 1'b1;
          curr_waddr = init_addr;
          prev_waddr = init_addr;
          curr_wdata = init_data;
          prev_wdata = init_data;
        end
        if (start) begin
          state_d = S_PRIME0;
          busy_d  = 1'b1;
        end
      end
      S_PRIME0: state_d = S_PRIME1;   // both banks read row 0
      S_PRIME1: begin
        center_d   = curr_rd_q;
        prev_d     = prev_rd_q;
        down_d     = '0;
        curr_raddr = ADDR_W'(1);
        state_d    = S_PRIME2;
      end
      S_PRIME2: begin
        up_d    = curr_rd_q;
        row_d   = '0;
        state_d = S_CALC;
      end
      S_CALC: begin
        unext_d = u_next;
        state_d = S_WR;
      end
      S_WR: begin
        curr_we  = 1'b1;
        prev_we  = 1'b1;
        down_d   = center_q;
        center_d = up_q;
        // Reads past the last row are parked at 0; the data is discarded.
        if (row_p2 < C_ROWS_X) curr_raddr = row_p2[ADDR_W-1:0];
        if (row_p1 < C_ROWS_X) prev_raddr = row_p1[ADDR_W-1:0];
`ifdef DRUM_PROBE_EN
        if (row_q == C_PROBE_ROW) probe_d = unext_q;
`endif
        if (row_q == C_LAST_ROW) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        up_d    = (row_p2 < C_ROWS_X) ? curr_rd_q : '0;
        prev_d  = prev_rd_q;
        row_d   = row_q + ADDR_W'(1);
        state_d = S_CALC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      center_q <= '0;
      up_q     <= '0;
      down_q   <= '0;
      prev_q   <= '0;
      unext_q  <= '0;
      row_q    <= '0;
`ifdef DRUM_PROBE_EN
      probe_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      center_q <= center_d;
      up_q     <= up_d;
      down_q   <= down_d;
      prev_q   <= prev_d;
      unext_q  <= unext_d;
      row_q    <= row_d;
`ifdef DRUM_PROBE_EN
      probe_q  <= probe_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign step_done = done_q;
  assign u_center  = center_q;
  assign u_up      = up_q;
  assign u_down    = down_q;
  assign u_prev    = prev_q;
  assign row       = row_q;

endmodule
`default_nettype wire

// File: tb/tb_drum_column_node.sv
`default_nettype none
// ============================================================================
// Module   : tb_drum_column_node
// Purpose  : Self-checking bench for drum_column_node. A reference model
//            holds the column as two plain arrays. Each step is modelled as
//            curr[i] += k and prev[i] = old curr[i]. The stencil values the
//            DUT shows in every CALC cycle are compared against snapshots of
//            the arrays taken at step start.
// Options  : compile with DRUM_PROBE_EN to also check probe_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drum_column_node;
  localparam int ROWS      = 30;
  localparam int ADDR_W    = 10;
  localparam int LAT       = 3 + 3 * ROWS;
  localparam int PROBE_ROW = ROWS / 2;

  logic              clk, reset_n, start, busy, step_done, init_we;
  logic [ADDR_W-1:0] init_addr, row;
  logic [17:0]       init_data, u_center, u_up, u_down, u_prev, u_next, k;
`ifdef DRUM_PROBE_EN
  logic [17:0]       probe_out;
`endif

  drum_column_node #(.ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
    .step_done(step_done), .init_we(init_we), .init_addr(init_addr),
    .init_data(init_data), .u_center(u_center), .u_up(u_up),
    .u_down(u_down), .u_prev(u_prev), .u_next(u_next), .row(row)
`ifdef DRUM_PROBE_EN
    , .probe_out(probe_out)
`endif
  );

  // Combinational solver stand-in: next value is the center plus k.
  always_comb u_next = u_center + k;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] m_curr [ROWS];
  logic [17:0] m_prev [ROWS];
  logic [17:0] m_probe;

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
  endtask

  task automatic init_row(input int a, input logic [17:0] d);
    @(negedge clk);
    init_we   = 1'b1;
    init_addr = a[ADDR_W-1:0];
    init_data = d;
    @(negedge clk);
    init_we   = 1'b0;
    m_curr[a] = d;
    m_prev[a] = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   18'(busy),      18'h0);
    check({tag, "_done"},   18'(step_done), 18'h0);
    check({tag, "_center"}, u_center,       18'h0);
    check({tag, "_up"},     u_up,           18'h0);
    check({tag, "_down"},   u_down,         18'h0);
    check({tag, "_prev"},   u_prev,         18'h0);
    check({tag, "_row"},    18'(row),       18'h0);
`ifdef DRUM_PROBE_EN
    check({tag, "_probe"},  probe_out,      18'h0);
`endif
  endtask

  // n is the index of the next rising edge after the start edge, so every
  // value looked at on iteration n is what that edge will sample.
  task automatic run_step(input logic [17:0] delta, input bit inject);
    logic [17:0] o_curr [ROWS];
    logic [17:0] o_prev [ROWS];
    logic [17:0] eu, ed;
    int r;
    o_curr = m_curr;
    o_prev = m_prev;
    k = delta;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 18'(busy), 18'h1);
    for (int n = 1; n <= LAT + 2; n++) begin
      if (n > 1) @(negedge clk);
      if (n >= 4 && (n - 4) % 3 == 0 && (n - 4) / 3 < ROWS) begin
        r  = (n - 4) / 3;
        eu = 18'h0;
        ed = 18'h0;
        if (r < ROWS - 1) eu = o_curr[r + 1];
        if (r > 0)        ed = o_curr[r - 1];
        check($sformatf("row_idx%0d", r), 18'(row), 18'(r));
        check($sformatf("center%0d", r), u_center, o_curr[r]);
        check($sformatf("up%0d", r),     u_up,     eu);
        check($sformatf("down%0d", r),   u_down,   ed);
        check($sformatf("prev%0d", r),   u_prev,   o_prev[r]);
        m_curr[r] = o_curr[r] + delta;
        m_prev[r] = o_curr[r];
        if (r == PROBE_ROW) m_probe = m_curr[r];
      end
      if (inject && n == 20) begin
        start     = 1'b1;
        init_we   = 1'b1;
        init_addr = ADDR_W'(5);
        init_data = 18'h12345;
      end
      if (inject && n == 21) begin
        start   = 1'b0;
        init_we = 1'b0;
      end
      if (n == LAT - 1) begin
        check("done_early", 18'(step_done), 18'h0);
        check("busy_before_done", 18'(busy), 18'h1);
      end
      if (n == LAT) begin
        check("done_at_lat", 18'(step_done), 18'h1);
        check("busy_at_done", 18'(busy), 18'h0);
`ifdef DRUM_PROBE_EN
        check("probe_at_done", probe_out, m_probe);
`endif
      end
      if (n == LAT + 1) check("done_pulse_width", 18'(step_done), 18'h0);
      if (n == LAT + 2) begin
        check("no_restart", 18'(busy), 18'h0);
`ifdef DRUM_PROBE_EN
        check("probe_hold", probe_out, m_probe);
`endif
      end
    end
  endtask

  // Async reset pulse while the DUT sits in PRIME2; memory is untouched.
  task automatic reset_mid_prime2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("prime2_center", u_center, m_curr[0]);
    check("prime2_prev",   u_prev,   m_prev[0]);
    reset_n = 1'b0;
    #1;
    m_probe = 18'h0;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 18'(busy), 18'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    init_we   = 1'b0;
    init_addr = '0;
    init_data = '0;
    k         = '0;
    m_probe   = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Single bump at row 15, identity solver, then a second step to observe.
    for (int i = 0; i < ROWS; i++) init_row(i, (i == 15) ? 18'h01000 : 18'h0);
    run_step(18'h0, 1'b0);
    run_step(18'h0, 1'b0);

    // Edge rows carry distinct values to expose missing zero boundaries.
    init_row(0, 18'h00800);
    init_row(ROWS - 1, 18'h3F800);
    run_step(18'h1, 1'b0);

    reset_mid_prime2();
    run_step(18'h1, 1'b0);

    // Back-to-back steps with a stray start and init write while busy.
    run_step(18'h1, 1'b1);
    run_step(18'h1, 1'b0);

    // Randomized column contents, increments and idle gaps.
    for (int i = 0; i < ROWS; i++) init_row(i, 18'($urandom));
    for (int s = 0; s < 4; s++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_step(18'($urandom), 1'($urandom_range(0, 1)));
    end
    run_step(18'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/drum_column_node.md
Name: drum_column_node

Overview:
- One column of the drum mesh; owns that column's displacement state and sequences it, row by row, through the per-node finite-difference solver.
- Holds u(t) and u(t-1) for ROWS nodes in two dual-port M10K banks.
- Presents center/up/down/prev to the combinational solver and exports its center value to the left/right neighbour columns.
- All columns run in lockstep from a shared start, so every column works on the same row in the same cycle.

Parameters:
- ROWS, 30, nodes in the column; legal range 3..1023.
- ADDR_W, 10, row address width; must satisfy 2^ADDR_W >= ROWS.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin one time step; sampled only in IDLE
- busy  out  1  high from start acceptance until step_done
- step_done  out  1  one-cycle pulse when the column step completes
- init_we  in  1  write init_data to both banks at init_addr; honoured only in IDLE
- init_addr  in  ADDR_W  init row
- init_data  in  18  init value, signed 1.17
- u_center  out  18  current-row u(t); goes to the neighbour columns and to the solver
- u_up  out  18  row i+1 u(t); 0 when i = ROWS-1
- u_down  out  18  row i-1 u(t); 0 when i = 0
- u_prev  out  18  row i u(t-1)
- u_next  in  18  solver result for the current row; combinational, valid in CALC
- row  out  ADDR_W  current row index

Behaviour:
- Reset: FSM goes to IDLE. busy, step_done, u_center, u_up, u_down, u_prev and row all clear to 0. Memory contents are untouched. A reset mid-step abandons the step with partial rows written; software must re-init.
- Memories: curr bank and prev bank. Each has a 1-cycle registered read and an independent write port. Read data is valid the cycle after the address is presented.
- States: IDLE, PRIME0, PRIME1, PRIME2, CALC, WR, LOAD.
- IDLE:
  - start moves to PRIME0 and sets busy.
  - init_we writes init_data to curr[init_addr] and prev[init_addr].
  - If start and init_we are asserted together, the init write happens and start is taken.
- PRIME0: read address 0 on both banks.
- PRIME1: capture u_center <= curr rdata and u_prev <= prev rdata; u_down <= 0; read curr address 1.
- PRIME2: u_up <= curr rdata; row <= 0.
- CALC: u_next is valid; capture it internally. Outputs are stable throughout CALC.
- WR:
  - Write curr[row] <= captured u_next and prev[row] <= u_center (the old u(t)).
  - Shift: u_down <= u_center, u_center <= u_up.
  - Read curr[row+2] and prev[row+1].
  - If row = ROWS-1, go to IDLE and pulse step_done; otherwise go to LOAD.
- LOAD:
  - u_up <= curr rdata, or 0 if row+2 >= ROWS.
  - u_prev <= prev rdata.
  - row <= row+1, then go to CALC.
- Read/write collision: the write to row i and the read of row i+2 never alias. Same-address read-during-write does not occur.
- Boundaries: the fixed edge is modelled by zero up/down values. Left/right edges are handled outside this block by tying the neighbour inputs of the end columns to 0.
- Latency: step_done is high exactly 3 + 3*ROWS cycles after the edge on which start is sampled (93 for ROWS=30). busy falls with the step_done pulse.
- start while busy is ignored. init_we while busy is ignored.
- Arithmetic: all data is 18-bit signed 1.17 and passes through unmodified; this block performs no arithmetic.

Optional Feature:
- Macro: DRUM_PROBE_EN
- Defined:
  - Adds parameter PROBE_ROW (default ROWS/2) and output probe_out [17:0], reset 0.
  - During WR with row = PROBE_ROW, probe_out <= u_next. It updates once per step and holds between steps; used as the audio sample.
- Undefined: no probe_out port and no probe logic.

Test Plan:
- Reset mid-PRIME2 with reset_n low for 1 cycle -> all outputs 0, state IDLE, busy 0; a following start gives a normal step with step_done at +93 cycles.
- ROWS=30: init all rows 0, row 15 = 18'sh01000; solver model = identity (u_next = u_center); start -> step_done 93 cycles later; prev[15]=01000, curr unchanged; in CALC for row 14, u_up = 01000.
- Boundary: init row0 = 18'sh00800, row29 = 18'sh3F800 -> in CALC for row 0, u_down = 0; for row 29, u_up = 0; for row 28, u_up = 3F800.
- Solver model u_next = u_center + 1; two back-to-back steps -> every curr[i] = init + 2 and prev[i] = init + 1; start pulsed during busy is ignored (the step count stays 2).
- init_we asserted while busy (addr 5, data 18'sh12345) -> no write; after step_done, curr[5] holds the solver result.
- DRUM_PROBE_EN, PROBE_ROW=15, solver u_next = 18'sh00400 -> probe_out = 00400 after the WR of row 15, stable through IDLE.
